// File: rtl/mem_store_unit_pkg.sv
// Package shared by the store unit and its lane aligner.
// Holds the RISC-V store funct3 codes, the error-cause codes reported on
// err_cause, and the FSM state encoding of mem_store_unit.
package mem_store_unit_pkg;

  // Store width encodings (funct3 field of S-type instructions).
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  // Fault causes, meaningful only while err is high.
  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_WAIT_ACK = 2'b01,
    ST_RESP     = 2'b10
  } state_e;

endpackage : mem_store_unit_pkg

// File: rtl/mem_store_unit_align.sv
// store_align: purely combinational lane shifter / strobe generator.
// Ports:
//   funct3     in  3   store width (SB/SH/SW)
//   addr_lo    in  2   address[1:0]
//   store_data in  32  rs2 value, data in the low bits
//   wdata      out 32  data replicated into every lane it may occupy
//   wstrb      out 4   byte enables, bit n = byte lane n
//   misaligned out 1   legal width but address not naturally aligned
//   illegal    out 1   funct3 is not a store width (wins over misaligned)
module store_align
  import mem_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        misaligned,
  output logic        illegal
);

  always_comb begin
    wdata      = 32'h0;
    wstrb      = 4'b0000;
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (funct3)
      F3_SB: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      F3_SH: begin
        wdata      = {2{store_data[15:0]}};
        wstrb      = addr_lo[1] ? 4'b1100 : 4'b0011;
        misaligned = addr_lo[0];
      end
      F3_SW: begin
        wdata      = store_data;
        wstrb      = 4'b1111;
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        // Illegal width: no lanes, and misaligned stays low so the
        // illegal cause always wins.
        illegal = 1'b1;
      end
    endcase
  end

endmodule : store_align

// File: rtl/mem_store_unit.sv
// mem_store_unit: takes one store at a time from the EX/MEM stage, checks
// width/alignment, issues a single word-aligned write to memory and reports
// completion (done) or a fault (err + err_cause + fault_addr).
//
// Handshake: a store is accepted on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE. mem_req stays high with stable addr/data/strb
// until the edge on which mem_ack is sampled high, or until the wait limit.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready store request handshake
//   funct3, address, store_data  store description from EX
//   mem_req/mem_addr/mem_wdata/mem_wstrb/mem_ack  memory write port
//   done, err           one-cycle completion / fault pulses (never together)
//   err_cause, fault_addr  fault details, valid while err=1
//   stall               high whenever not IDLE
//   dbg_state           current FSM state
module mem_store_unit
  import mem_store_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_cause,
  output logic [31:0] fault_addr,
  output logic        stall,
  output state_e      dbg_state
);

  // Last count value before giving up on mem_ack.
  localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        fault_q, fault_d;
  logic [1:0]  cause_q, cause_d;
  logic [31:0] fault_addr_q, fault_addr_d;

  logic [31:0] al_wdata;
  logic [3:0]  al_wstrb;
  logic        al_misaligned;
  logic        al_illegal;

  store_align u_align (
    .funct3     (funct3),
    .addr_lo    (address[1:0]),
    .store_data (store_data),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    fault_d      = fault_q;
    cause_d      = cause_q;
    fault_addr_d = fault_addr_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          // Original address is kept for any later fault report.
          fault_addr_d = address;
          if (al_illegal) begin
            state_d = ST_RESP;
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (al_misaligned) begin
            state_d = ST_RESP;
            fault_d = 1'b1;
            cause_d = CAUSE_MISALIGN;
          end else begin
            state_d = ST_WAIT_ACK;
            cnt_d   = 8'd0;
            addr_d  = {address[31:2], 2'b00};
            wdata_d = al_wdata;
            wstrb_d = al_wstrb;
            fault_d = 1'b0;
            cause_d = CAUSE_NONE;
          end
        end
      end
      ST_WAIT_ACK: begin
        // An ack on the limit cycle still counts as success.
        if (mem_ack) begin
          state_d = ST_RESP;
          fault_d = 1'b0;
          cause_d = CAUSE_NONE;
        end else if (cnt_q == WAIT_LIMIT) begin
          state_d = ST_RESP;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'b0000;
      fault_q      <= 1'b0;
      cause_q      <= CAUSE_NONE;
      fault_addr_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // All handshake/pulse outputs decode directly from registered state.
  assign req_ready  = (state_q == ST_IDLE);
  assign mem_req    = (state_q == ST_WAIT_ACK);
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;
  assign done       = (state_q == ST_RESP) && !fault_q;
  assign err        = (state_q == ST_RESP) && fault_q;
  assign err_cause  = cause_q;
  assign fault_addr = fault_addr_q;
  assign stall      = (state_q != ST_IDLE);
  assign dbg_state  = state_q;

endmodule : mem_store_unit
